// File: rtl/dmem_responder_if.sv
// Data-memory bus between the pipeline memory stage (master) and a responder.
interface dmem_if;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  byte_en;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        ack;
  logic        err;

  modport master (
    output addr, wr_data, byte_en, wr_en, rd_en,
    input  rd_data, ack, err
  );

  modport slave (
    input  addr, wr_data, byte_en, wr_en, rd_en,
    output rd_data, ack, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory answering dmem_if requests after a fixed
// number of wait cycles, with a single-cycle ack and an error qualifier
// for out-of-window addresses or conflicting read+write requests.
module dmem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic  i_clk,
  input  logic  i_rst,
  dmem_if.slave from_cpu,
  output logic  o_busy
);

  localparam int unsigned AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] SPAN     = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, next_state;
  logic [3:0]      cnt;
  logic [31:0]     mem [MEM_WORDS];

  logic            req;
  logic [31:0]     offset;
  logic            in_range;
  logic [AW-1:0]   req_idx;
  logic            req_bad;

  logic [AW-1:0]   idx_q;
  logic            bad_q;
  logic            wr_q;
  logic [31:0]     wr_data_q;
  logic [3:0]      be_q;

  logic [AW-1:0]   cur_idx;
  logic            cur_bad;
  logic            cur_wr;

  logic            ack_q;
  logic            err_q;
  logic [31:0]     rd_data_q;

  // Decode the live request: window check on the full offset, word index from it
  always_comb begin
    req      = from_cpu.rd_en | from_cpu.wr_en;
    offset   = from_cpu.addr - BASE_ADDR;
    in_range = (from_cpu.addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    req_idx  = offset[AW+1:2];
    req_bad  = !in_range || (from_cpu.rd_en && from_cpu.wr_en);
  end

  // With zero latency RESP is entered straight from IDLE, so the response
  // must be built from the live inputs rather than the just-captured copy
  always_comb begin
    cur_idx = (state == IDLE) ? req_idx        : idx_q;
    cur_bad = (state == IDLE) ? req_bad        : bad_q;
    cur_wr  = (state == IDLE) ? from_cpu.wr_en : wr_q;
  end

  // State register and wait counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == WAIT)
        cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 4'd1;
      else
        cnt <= '0;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture the accepted request; later input activity is ignored
  always_ff @(posedge i_clk) begin
    if (state == IDLE && req) begin
      idx_q     <= req_idx;
      bad_q     <= req_bad;
      wr_q      <= from_cpu.wr_en;
      wr_data_q <= from_cpu.wr_data;
      be_q      <= from_cpu.byte_en;
    end
  end

  // Registered response, populated only for the RESP cycle
  always_ff @(posedge i_clk) begin
    if (i_rst || next_state != RESP) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      ack_q     <= 1'b1;
      err_q     <= cur_bad;
      rd_data_q <= (cur_bad || cur_wr) ? '0 : mem[cur_idx];
    end
  end

  // Lane-masked array write at the edge that ends RESP; never cleared by reset
  always_ff @(posedge i_clk) begin
    if (!i_rst && state == RESP && wr_q && !bad_q) begin
      for (int unsigned lane = 0; lane < 4; lane++) begin
        if (be_q[lane]) mem[idx_q][8*lane +: 8] <= wr_data_q[8*lane +: 8];
      end
    end
  end

  // Drive outputs from registered state
  always_comb begin
    o_busy           = (state != IDLE);
    from_cpu.ack     = ack_q;
    from_cpu.err     = err_q;
    from_cpu.rd_data = rd_data_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances with different latency/base/size,
// compared against a word-array reference model with exact ack timing.
module tb_dmem_responder;

  localparam int NDUT = 4;
  localparam int unsigned LATS  [NDUT] = '{2, 0, 3, 1};
  localparam int unsigned WORDS [NDUT] = '{64, 64, 64, 16};
  localparam logic [31:0] BASES [NDUT] = '{32'h0, 32'h0, 32'h0, 32'h0000_1000};

  logic        clk;
  logic        rst_v   [NDUT];
  logic        rd_v    [NDUT];
  logic        wr_v    [NDUT];
  logic [31:0] addr_v  [NDUT];
  logic [31:0] wd_v    [NDUT];
  logic [3:0]  be_v    [NDUT];
  logic        ack_v   [NDUT];
  logic        err_v   [NDUT];
  logic        busy_v  [NDUT];
  logic [31:0] rdd_v   [NDUT];

  logic [31:0] mdl [NDUT][64];

  int total;
  int nbad;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_if bus ();
    dmem_responder #(
      .MEM_WORDS(WORDS[g]),
      .LATENCY  (LATS[g]),
      .BASE_ADDR(BASES[g])
    ) dut (
      .i_clk   (clk),
      .i_rst   (rst_v[g]),
      .from_cpu(bus),
      .o_busy  (busy_v[g])
    );
    assign bus.addr    = addr_v[g];
    assign bus.wr_data = wd_v[g];
    assign bus.byte_en = be_v[g];
    assign bus.wr_en   = wr_v[g];
    assign bus.rd_en   = rd_v[g];
    assign ack_v[g]    = bus.ack;
    assign err_v[g]    = bus.err;
    assign rdd_v[g]    = bus.rd_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outcome of a request from the address window and op rules
  function automatic logic is_err(int d, logic rd, logic wr, logic [31:0] a);
    longint unsigned lo, hi;
    lo = longint'(BASES[d]);
    hi = lo + 4 * longint'(WORDS[d]);
    return (longint'(a) < lo) || (longint'(a) >= hi) || (rd && wr);
  endfunction

  function automatic int word_of(int d, logic [31:0] a);
    return int'((longint'(a) - longint'(BASES[d])) / 4);
  endfunction

  // One complete transaction: request held for one edge, ack expected
  // exactly LATENCY+1 cycles after acceptance, then an idle cycle.
  task automatic txn(input int d, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input string tag);
    logic        e_err;
    logic [31:0] e_rd;
    int          w;
    int unsigned lat;
    lat   = LATS[d];
    e_err = is_err(d, rd, wr, a);
    w     = e_err ? 0 : word_of(d, a);
    e_rd  = (!e_err && rd) ? mdl[d][w] : 32'h0;
    @(posedge clk); #1;
    rd_v[d] = rd; wr_v[d] = wr; addr_v[d] = a; wd_v[d] = wd; be_v[d] = be;
    @(posedge clk); #1;
    rd_v[d] = 1'b0; wr_v[d] = 1'b0;
    addr_v[d] = $urandom; wd_v[d] = $urandom; be_v[d] = 4'($urandom);
    for (int unsigned k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      chk({tag, "/busy"}, 32'(busy_v[d]), 32'd1);
      chk({tag, "/ack"}, 32'(ack_v[d]), (k == lat + 1) ? 32'd1 : 32'd0);
      if (k == lat + 1) begin
        chk({tag, "/rd_data"}, rdd_v[d], e_rd);
        chk({tag, "/err"}, 32'(err_v[d]), 32'(e_err));
      end
    end
    if (!e_err && wr) begin
      for (int l = 0; l < 4; l++)
        if (be[l]) mdl[d][w][8*l +: 8] = wd[8*l +: 8];
    end
    @(negedge clk);
    chk({tag, "/idle_ack"}, 32'(ack_v[d]), 32'd0);
    chk({tag, "/idle_busy"}, 32'(busy_v[d]), 32'd0);
    chk({tag, "/idle_rd"}, rdd_v[d], 32'h0);
    chk({tag, "/idle_err"}, 32'(err_v[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          op;
    total = 0;
    nbad  = 0;
    for (int d = 0; d < NDUT; d++) begin
      rst_v[d] = 1'b1; rd_v[d] = 1'b0; wr_v[d] = 1'b0;
      addr_v[d] = '0; wd_v[d] = '0; be_v[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("reset/ack", 32'(ack_v[d]), 32'd0);
      chk("reset/busy", 32'(busy_v[d]), 32'd0);
      chk("reset/err", 32'(err_v[d]), 32'd0);
      chk("reset/rd_data", rdd_v[d], 32'h0);
    end
    @(posedge clk); #1;
    for (int d = 0; d < NDUT; d++) rst_v[d] = 1'b0;

    // Give every word a known value
    for (int d = 0; d < NDUT; d++)
      for (int w = 0; w < int'(WORDS[d]); w++)
        txn(d, 1'b0, 1'b1, BASES[d] + 32'(4 * w), $urandom, 4'hF, "init");

    // Full write then read, then a single-lane update
    txn(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "wr_full");
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "rd_full");
    txn(0, 1'b0, 1'b1, 32'h10, 32'h0000_5500, 4'b0010, "wr_lane1");
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "rd_lane1");
    txn(0, 1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, "wr_noen");
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "rd_noen");

    // Error cases: just past the top, conflicting ops, then readback
    txn(0, 1'b1, 1'b0, 32'(4 * WORDS[0]), 32'h0, 4'h0, "rd_top");
    txn(0, 1'b0, 1'b1, 32'(4 * WORDS[0]), 32'hAAAA_AAAA, 4'hF, "wr_top");
    txn(0, 1'b1, 1'b1, 32'h10, 32'h1111_1111, 4'hF, "rd_wr_both");
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "rd_after_err");
    txn(0, 1'b1, 1'b0, 32'(4 * WORDS[0] - 4), 32'h0, 4'h0, "rd_last");

    // Non-zero base window edges and ignored low address bits
    txn(3, 1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, "b_below");
    txn(3, 1'b1, 1'b0, 32'h0000_1040, 32'h0, 4'h0, "b_above");
    txn(3, 1'b1, 1'b0, 32'h0000_103C, 32'h0, 4'h0, "b_last");
    txn(3, 1'b0, 1'b1, 32'h0000_1002, 32'hCAFE_F00D, 4'b1001, "b_wr_unal");
    txn(3, 1'b1, 1'b0, 32'h0000_1001, 32'h0, 4'h0, "b_rd_unal");

    // Zero latency, read enable held: ack every other cycle
    @(posedge clk); #1;
    rd_v[1] = 1'b1; addr_v[1] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) addr_v[1] = 32'(4 * (i + 1));
      else rd_v[1] = 1'b0;
      @(negedge clk);
      chk("b2b/ack", 32'(ack_v[1]), 32'd1);
      chk("b2b/busy", 32'(busy_v[1]), 32'd1);
      chk("b2b/rd_data", rdd_v[1], mdl[1][i]);
      chk("b2b/err", 32'(err_v[1]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("b2b/gap_ack", 32'(ack_v[1]), 32'd0);
      chk("b2b/gap_busy", 32'(busy_v[1]), 32'd0);
    end

    // Zero latency, write held then switched to read of the same word
    @(posedge clk); #1;
    wr_v[1] = 1'b1; addr_v[1] = 32'h24; wd_v[1] = 32'h0BAD_F00D; be_v[1] = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr2rd/wack", 32'(ack_v[1]), 32'd1);
    wr_v[1] = 1'b0; rd_v[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd_v[1] = 1'b0;
    @(negedge clk);
    chk("wr2rd/rack", 32'(ack_v[1]), 32'd1);
    chk("wr2rd/rd_data", rdd_v[1], 32'h0BAD_F00D);
    mdl[1][9] = 32'h0BAD_F00D;
    @(posedge clk);

    // Reset while waiting aborts the write
    @(posedge clk); #1;
    wr_v[2] = 1'b1; addr_v[2] = 32'h20; wd_v[2] = 32'h1234_5678; be_v[2] = 4'hF;
    @(posedge clk); #1;
    wr_v[2] = 1'b0;
    @(posedge clk); #1;
    rst_v[2] = 1'b1;
    @(negedge clk);
    chk("abort/busy_before", 32'(busy_v[2]), 32'd1);
    @(posedge clk); #1;
    rst_v[2] = 1'b0;
    @(negedge clk);
    chk("abort/ack", 32'(ack_v[2]), 32'd0);
    chk("abort/busy", 32'(busy_v[2]), 32'd0);
    chk("abort/err", 32'(err_v[2]), 32'd0);
    chk("abort/rd_data", rdd_v[2], 32'h0);
    @(negedge clk);
    chk("abort/late_ack", 32'(ack_v[2]), 32'd0);
    txn(2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, "abort/readback");

    // Random mix of reads, writes, conflicts and out-of-window addresses
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 40; i++) begin
        op = int'($urandom_range(0, 3));
        a  = BASES[d] - 32'd8 + 32'($urandom_range(0, 4 * WORDS[d] + 15));
        txn(d, op != 2, op >= 2, a, $urandom, 4'($urandom_range(0, 15)), "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
